// File: rtl/dram_read_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dram_read_responder_if
// Description : Bundles the cache-side single-word read handshake and the
//               DRAM controller user-interface signals that the responder
//               sits between.
//               slave  : view used by dram_read_responder
//               master : view used by whatever drives the cache and DRAM sides
// Signals     : oe / addr          - read request pulse and word address
//               rdata / valid      - returned word and one-cycle response
//               busy               - request in flight
//               dram_cmd_en/_rdy   - line read command handshake
//               dram_addr          - line address
//               dram_rd_valid/data - returned line
// Revision    : 1.0 - initial release
// ============================================================================
interface dram_read_responder_if #(
  parameter int MEM_SCALE = 27,
  parameter int LINE_LOG  = 2
);
  localparam int DW = 32 << LINE_LOG;

  logic                          oe;
  logic [MEM_SCALE-1:0]          addr;
  logic [31:0]                   rdata;
  logic                          valid;
  logic                          busy;
  logic                          dram_cmd_en;
  logic                          dram_cmd_rdy;
  logic [MEM_SCALE-LINE_LOG-1:0] dram_addr;
  logic                          dram_rd_valid;
  logic [DW-1:0]                 dram_rd_data;

  modport slave (
    input  oe, addr, dram_cmd_rdy, dram_rd_valid, dram_rd_data,
    output rdata, valid, busy, dram_cmd_en, dram_addr
  );

  modport master (
    output oe, addr, dram_cmd_rdy, dram_rd_valid, dram_rd_data,
    input  rdata, valid, busy, dram_cmd_en, dram_addr
  );
endinterface
`default_nettype wire

// File: rtl/dram_read_responder.sv
`default_nettype none
// ============================================================================
// Module      : dram_read_responder
// Description : Memory-side responder for the instruction cache refill port.
//               Takes a one-cycle oe pulse with a word address, fetches the
//               containing line from the DRAM controller, and returns the
//               selected 32-bit word with a one-cycle valid pulse. One request
//               is outstanding at a time.
// Ports       : clk            - clock
//               rst_n          - asynchronous active-low reset
//               inval_i        - line buffer invalidate (DRAM_READ_LINEBUF_EN)
//               bus            - cache/DRAM handshake (dram_read_responder_if)
//               err_overrun_o  - sticky, request arrived while busy
//               cnt_req_o      - accepted requests (wraps)
//               cnt_dram_o     - DRAM line commands issued (wraps)
// Options     : `define DRAM_READ_LINEBUF_EN keeps the last fetched line and
//               answers same-line requests without a DRAM command.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_read_responder #(
  parameter int MEM_SCALE = 27,
  parameter int LINE_LOG  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef DRAM_READ_LINEBUF_EN
  input  logic                   inval_i,
`endif
  dram_read_responder_if.slave   bus,
  output logic                   err_overrun_o,
  output logic [31:0]            cnt_req_o,
  output logic [31:0]            cnt_dram_o
);

  localparam int DW    = 32 << LINE_LOG;
  localparam int WORDS = 1 << LINE_LOG;
  localparam int TAG_W = MEM_SCALE - LINE_LOG;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_WAIT = 3'd2,
    S_HIT  = 3'd3,
    S_RESP = 3'd4
  } state_e;

  state_e               state_q;
  logic [MEM_SCALE-1:0] addr_q;
  logic [31:0]          rdata_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 cmd_en_q;
  logic [TAG_W-1:0]     dram_addr_q;
  logic                 err_q;
  logic [31:0]          cnt_req_q;
  logic [31:0]          cnt_dram_q;

  // Word selection out of the incoming DRAM line.
  logic [31:0] rd_words_d [WORDS];
  logic [31:0] rd_word_d;

  for (genvar i = 0; i < WORDS; i++) begin : g_rd_words
    assign rd_words_d[i] = bus.dram_rd_data[32*i +: 32];
  end

  assign rd_word_d = rd_words_d[addr_q[LINE_LOG-1:0]];

  logic        hit_d;
  logic [31:0] buf_word_d;

`ifdef DRAM_READ_LINEBUF_EN
  logic [DW-1:0]    line_q;
  logic [TAG_W-1:0] tag_q;
  logic             line_vld_q;
  logic [31:0]      buf_words_d [WORDS];

  for (genvar i = 0; i < WORDS; i++) begin : g_buf_words
    assign buf_words_d[i] = line_q[32*i +: 32];
  end

  // An invalidate in the same cycle as the request must force a miss.
  assign hit_d      = line_vld_q && !inval_i && (tag_q == bus.addr[MEM_SCALE-1:LINE_LOG]);
  assign buf_word_d = buf_words_d[addr_q[LINE_LOG-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q     <= '0;
      tag_q      <= '0;
      line_vld_q <= 1'b0;
    end else begin
      if (state_q == S_WAIT && bus.dram_rd_valid) begin
        line_q     <= bus.dram_rd_data;
        tag_q      <= addr_q[MEM_SCALE-1:LINE_LOG];
        line_vld_q <= 1'b1;
      end
      // Invalidate wins over a fill landing in the same cycle.
      if (inval_i) begin
        line_vld_q <= 1'b0;
      end
    end
  end
`else
  assign hit_d      = 1'b0;
  assign buf_word_d = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rdata_q     <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      cmd_en_q    <= 1'b0;
      dram_addr_q <= '0;
      err_q       <= 1'b0;
      cnt_req_q   <= '0;
      cnt_dram_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.oe) begin
            addr_q    <= bus.addr;
            cnt_req_q <= cnt_req_q + 32'd1;
            busy_q    <= 1'b1;
            if (hit_d) begin
              // Extra cycle keeps hit latency at two cycles from oe.
              state_q <= S_HIT;
            end else begin
              state_q     <= S_CMD;
              cmd_en_q    <= 1'b1;
              dram_addr_q <= bus.addr[MEM_SCALE-1:LINE_LOG];
            end
          end
        end
        S_CMD: begin
          if (bus.dram_cmd_rdy) begin
            cmd_en_q   <= 1'b0;
            cnt_dram_q <= cnt_dram_q + 32'd1;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.dram_rd_valid) begin
            rdata_q <= rd_word_d;
            valid_q <= 1'b1;
            state_q <= S_RESP;
          end
        end
        S_HIT: begin
          rdata_q <= buf_word_d;
          valid_q <= 1'b1;
          state_q <= S_RESP;
        end
        S_RESP: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q  <= 1'b0;
          busy_q   <= 1'b0;
          cmd_en_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase

      // Any request outside IDLE (including the valid cycle) is dropped.
      if (bus.oe && state_q != S_IDLE) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.rdata       = rdata_q;
  assign bus.valid       = valid_q;
  assign bus.busy        = busy_q;
  assign bus.dram_cmd_en = cmd_en_q;
  assign bus.dram_addr   = dram_addr_q;
  assign err_overrun_o   = err_q;
  assign cnt_req_o       = cnt_req_q;
  assign cnt_dram_o      = cnt_dram_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_read_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_read_responder
// Description : Self-checking bench for dram_read_responder. A behavioural
//               DRAM model answers line reads from a word-addressed memory
//               image with programmable command/data delays; a request-level
//               model predicts data, latency and counters.
// Options     : DRAM_READ_LINEBUF_EN enables the line buffer scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_read_responder;

  localparam int MS = 27;
  localparam int LL = 2;

  logic        clk;
  logic        rst_n;
  logic        err_overrun;
  logic [31:0] cnt_req;
  logic [31:0] cnt_dram;
`ifdef DRAM_READ_LINEBUF_EN
  logic        inval;
  logic        m_vld;
  logic [24:0] m_line;
`endif

  dram_read_responder_if #(.MEM_SCALE(MS), .LINE_LOG(LL)) bus ();

  dram_read_responder #(.MEM_SCALE(MS), .LINE_LOG(LL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef DRAM_READ_LINEBUF_EN
    .inval_i       (inval),
`endif
    .bus           (bus),
    .err_overrun_o (err_overrun),
    .cnt_req_o     (cnt_req),
    .cnt_dram_o    (cnt_dram)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int exp_req  = 0;
  int exp_dram = 0;
  int rdy_delay = 0;
  int rv_delay  = 0;
  int n_cmd     = 0;
  int n_valid   = 0;

  // Memory image: explicit words override a distinct-per-address default.
  logic [31:0] mem [logic [26:0]];

  function automatic logic [31:0] word_of(input logic [26:0] a);
    if (mem.exists(a)) return mem[a];
    return {5'h15, a} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [127:0] line_of(input logic [24:0] ln);
    logic [127:0] d;
    for (int i = 0; i < 4; i++) d[32*i +: 32] = word_of({ln, 2'(i)});
    return d;
  endfunction

  // DRAM controller model: decides rdy / rd_valid for the next rising edge.
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [24:0] pend_line = '0;
  int          en_cnt = 0;

  always @(negedge clk) begin
    bus.dram_rd_valid = 1'b0;
    bus.dram_rd_data  = {$urandom, $urandom, $urandom, $urandom};
    if (pend) begin
      if (pend_cnt == 0) begin
        bus.dram_rd_valid = 1'b1;
        bus.dram_rd_data  = line_of(pend_line);
        pend = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (bus.dram_cmd_en === 1'b1) begin
      if (en_cnt >= rdy_delay) begin
        bus.dram_cmd_rdy = 1'b1;
        pend      = 1'b1;
        pend_cnt  = rv_delay;
        pend_line = bus.dram_addr;
        en_cnt    = 0;
        n_cmd++;
      end else begin
        bus.dram_cmd_rdy = 1'b0;
        en_cnt++;
      end
    end else begin
      bus.dram_cmd_rdy = 1'b0;
      en_cnt = 0;
    end
  end

  always @(negedge clk) if (bus.valid === 1'b1) n_valid++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_req  = 0;
    exp_dram = 0;
`ifdef DRAM_READ_LINEBUF_EN
    m_vld = 1'b0;
`endif
  endtask

  // Request-level prediction: one request, buffered same-line hit or a fetch.
  task automatic model_req(input logic [26:0] a, input logic inv, output logic hit);
    hit = 1'b0;
`ifdef DRAM_READ_LINEBUF_EN
    hit = m_vld && !inv && (a[26:2] == m_line);
    if (!hit) begin
      m_vld  = 1'b1;
      m_line = a[26:2];
    end
`else
    if (inv) hit = 1'b0;
`endif
    exp_req++;
    if (!hit) exp_dram++;
  endtask

  function automatic int exp_lat(input logic hit);
    return hit ? 2 : 3 + rdy_delay + rv_delay;
  endfunction

  task automatic set_inval(input logic v);
`ifdef DRAM_READ_LINEBUF_EN
    inval = v;
`else
    if (v) bus.addr = bus.addr;
`endif
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    bus.oe = 1'b0;
    set_inval(1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  // Issue one request and wait (bounded) for the response; ends in the valid cycle.
  task automatic run_req(input logic [26:0] a, input logic inv, output int lat, output logic [31:0] data);
    bus.oe   = 1'b1;
    bus.addr = a;
    set_inval(inv);
    tick();
    bus.oe   = 1'b0;
    set_inval(1'b0);
    bus.addr = 27'($urandom);
    lat  = -1;
    data = 32'hx;
    for (int k = 1; k <= 200; k++) begin
      if (bus.valid === 1'b1) begin
        lat  = k;
        data = bus.rdata;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.dram_cmd_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", bus.dram_cmd_en); end
    n_checks++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_overrun); end
    n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
    n_checks++; if (bus.dram_addr !== 25'h0) begin n_fail++; $display("FAIL reset_daddr: got %h expected 0", bus.dram_addr); end
    n_checks++; if (cnt_req !== 32'h0) begin n_fail++; $display("FAIL reset_cnt_req: got %0d expected 0", cnt_req); end
    n_checks++; if (cnt_dram !== 32'h0) begin n_fail++; $display("FAIL reset_cnt_dram: got %0d expected 0", cnt_dram); end
  endtask

  task automatic test_min_latency();
    logic hit;
    apply_reset();
    rdy_delay = 0;
    rv_delay  = 0;
    mem[27'h0000123] = 32'hDEADBEEF;
    model_req(27'h0000123, 1'b0, hit);
    bus.oe   = 1'b1;
    bus.addr = 27'h0000123;
    tick();                                   // cycle 1
    bus.oe = 1'b0;
    n_checks++; if (bus.dram_cmd_en !== 1'b1) begin n_fail++; $display("FAIL minlat_en: got %b expected 1", bus.dram_cmd_en); end
    n_checks++; if (bus.dram_addr !== 25'h48) begin n_fail++; $display("FAIL minlat_daddr: got %h expected 48", bus.dram_addr); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL minlat_busy: got %b expected 1", bus.busy); end
    tick();                                   // cycle 2
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL minlat_early_valid: got %b expected 0", bus.valid); end
    tick();                                   // cycle 3
    n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL minlat_valid: got %b expected 1", bus.valid); end
    n_checks++; if (bus.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL minlat_rdata: got %h expected deadbeef", bus.rdata); end
    n_checks++; if (cnt_req !== 32'(exp_req)) begin n_fail++; $display("FAIL minlat_cnt_req: got %0d expected %0d", cnt_req, exp_req); end
    n_checks++; if (cnt_dram !== 32'(exp_dram)) begin n_fail++; $display("FAIL minlat_cnt_dram: got %0d expected %0d", cnt_dram, exp_dram); end
    tick();                                   // cycle 4
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL minlat_valid_drop: got %b expected 0", bus.valid); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL minlat_busy_drop: got %b expected 0", bus.busy); end
  endtask

  task automatic test_rdy_stall();
    logic hit;
    int c0, v0, lat;
    logic [31:0] d;
    rdy_delay = 5;
    rv_delay  = 0;
    c0 = n_cmd;
    v0 = n_valid;
    model_req(27'h0000ABC, 1'b0, hit);
    bus.oe = 1'b1; bus.addr = 27'h0000ABC;
    tick();
    bus.oe = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (bus.dram_cmd_en !== 1'b1 || bus.dram_addr !== 25'h2AF) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got en=%b addr=%h expected en=1 addr=2af", k, bus.dram_cmd_en, bus.dram_addr);
      end
      tick();
    end
    lat = -1; d = 32'hx;
    for (int k = 6; k <= 200; k++) begin
      if (bus.valid === 1'b1) begin lat = k; d = bus.rdata; break; end
      tick();
    end
    n_checks++; if (lat != exp_lat(hit)) begin n_fail++; $display("FAIL stall_latency: got %0d expected %0d", lat, exp_lat(hit)); end
    n_checks++; if (d !== word_of(27'h0000ABC)) begin n_fail++; $display("FAIL stall_rdata: got %h expected %h", d, word_of(27'h0000ABC)); end
    repeat (4) tick();
    n_checks++; if (n_valid - v0 != 1) begin n_fail++; $display("FAIL stall_valid_count: got %0d expected 1", n_valid - v0); end
    n_checks++; if (n_cmd - c0 != 1) begin n_fail++; $display("FAIL stall_cmd_count: got %0d expected 1", n_cmd - c0); end
    n_checks++; if (cnt_dram !== 32'(exp_dram)) begin n_fail++; $display("FAIL stall_cnt_dram: got %0d expected %0d", cnt_dram, exp_dram); end
  endtask

  task automatic test_overrun();
    logic hit;
    int c0, v0, lat;
    logic [31:0] d;
    apply_reset();
    rdy_delay = 0;
    rv_delay  = 4;
    c0 = n_cmd;
    model_req(27'h0000777, 1'b0, hit);
    bus.oe = 1'b1; bus.addr = 27'h0000777;
    tick(); bus.oe = 1'b0;
    tick(); tick();                           // now waiting for line data
    bus.oe = 1'b1; bus.addr = 27'h0000999;
    tick(); bus.oe = 1'b0;
    lat = -1; d = 32'hx;
    for (int k = 4; k <= 200; k++) begin
      if (bus.valid === 1'b1) begin lat = k; d = bus.rdata; break; end
      tick();
    end
    n_checks++; if (d !== word_of(27'h0000777)) begin n_fail++; $display("FAIL ovr_rdata: got %h expected %h", d, word_of(27'h0000777)); end
    n_checks++; if (lat != exp_lat(hit)) begin n_fail++; $display("FAIL ovr_latency: got %0d expected %0d", lat, exp_lat(hit)); end
    n_checks++; if (err_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_err: got %b expected 1", err_overrun); end
    n_checks++; if (cnt_req !== 32'(exp_req)) begin n_fail++; $display("FAIL ovr_cnt_req: got %0d expected %0d", cnt_req, exp_req); end
    repeat (6) tick();
    n_checks++; if (n_cmd - c0 != 1) begin n_fail++; $display("FAIL ovr_cmd_count: got %0d expected 1", n_cmd - c0); end
    n_checks++; if (bus.busy !== 1'b0 || bus.dram_cmd_en !== 1'b0) begin n_fail++; $display("FAIL ovr_idle: got busy=%b en=%b expected 0 0", bus.busy, bus.dram_cmd_en); end

    // Request landing in the valid cycle is dropped and flagged.
    apply_reset();
    rv_delay = 0;
    n_checks++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_err_cleared: got %b expected 0", err_overrun); end
    c0 = n_cmd;
    v0 = n_valid;
    model_req(27'h0000555, 1'b0, hit);
    run_req(27'h0000555, 1'b0, lat, d);
    bus.oe = 1'b1; bus.addr = 27'h0000E00;
    tick(); bus.oe = 1'b0;
    repeat (4) tick();
    n_checks++; if (err_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_cycle_err: got %b expected 1", err_overrun); end
    n_checks++; if (cnt_req !== 32'(exp_req)) begin n_fail++; $display("FAIL ovr_valid_cycle_cnt: got %0d expected %0d", cnt_req, exp_req); end
    n_checks++; if (n_cmd - c0 != 1 || n_valid - v0 != 1) begin n_fail++; $display("FAIL ovr_valid_cycle_txn: got cmds=%0d valids=%0d expected 1 1", n_cmd - c0, n_valid - v0); end
  endtask

  task automatic test_reset_in_wait();
    logic hit;
    int v0;
    rdy_delay = 0;
    rv_delay  = 6;
    model_req(27'h0001ABC, 1'b0, hit);
    bus.oe = 1'b1; bus.addr = 27'h0001ABC;
    tick(); bus.oe = 1'b0;
    tick(); tick();                           // command accepted, data pending
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    model_reset();
    v0 = n_valid;
    repeat (12) tick();                       // stale line data arrives here
    n_checks++; if (n_valid != v0) begin n_fail++; $display("FAIL rstwait_no_valid: got %0d expected 0", n_valid - v0); end
    n_checks++; if (bus.busy !== 1'b0 || bus.dram_cmd_en !== 1'b0 || err_overrun !== 1'b0) begin
      n_fail++; $display("FAIL rstwait_flags: got busy=%b en=%b err=%b expected 0 0 0", bus.busy, bus.dram_cmd_en, err_overrun);
    end
    n_checks++; if (bus.rdata !== 32'h0 || bus.dram_addr !== 25'h0) begin n_fail++; $display("FAIL rstwait_data: got rdata=%h daddr=%h expected 0 0", bus.rdata, bus.dram_addr); end
    n_checks++; if (cnt_req !== 32'h0 || cnt_dram !== 32'h0) begin n_fail++; $display("FAIL rstwait_cnt: got %0d %0d expected 0 0", cnt_req, cnt_dram); end
  endtask

  task automatic test_back_to_back();
    logic hit;
    int lat;
    logic [31:0] d;
    apply_reset();
    rdy_delay = 0;
    rv_delay  = 1;
    model_req(27'h10, 1'b0, hit);
    run_req(27'h10, 1'b0, lat, d);
    n_checks++; if (d !== word_of(27'h10) || lat != exp_lat(hit)) begin n_fail++; $display("FAIL b2b_first: got %h lat %0d expected %h lat %0d", d, lat, word_of(27'h10), exp_lat(hit)); end
    tick();
    model_req(27'h11, 1'b0, hit);
    run_req(27'h11, 1'b0, lat, d);
    n_checks++; if (d !== word_of(27'h11) || lat != exp_lat(hit)) begin n_fail++; $display("FAIL b2b_second: got %h lat %0d expected %h lat %0d", d, lat, word_of(27'h11), exp_lat(hit)); end
    tick();
    n_checks++; if (cnt_req !== 32'd2) begin n_fail++; $display("FAIL b2b_cnt_req: got %0d expected 2", cnt_req); end
    n_checks++; if (cnt_dram !== 32'(exp_dram)) begin n_fail++; $display("FAIL b2b_cnt_dram: got %0d expected %0d", cnt_dram, exp_dram); end
  endtask

`ifdef DRAM_READ_LINEBUF_EN
  task automatic test_linebuf();
    logic hit;
    int lat;
    logic [31:0] d;
    apply_reset();
    rdy_delay = 0;
    rv_delay  = 0;
    model_req(27'h10, 1'b0, hit);
    run_req(27'h10, 1'b0, lat, d);
    tick();
    model_req(27'h11, 1'b0, hit);
    run_req(27'h11, 1'b0, lat, d);
    tick();
    n_checks++; if (lat != 2 || d !== word_of(27'h11)) begin n_fail++; $display("FAIL lb_hit: got lat %0d data %h expected lat 2 data %h", lat, d, word_of(27'h11)); end
    n_checks++; if (cnt_dram !== 32'd1) begin n_fail++; $display("FAIL lb_hit_cnt_dram: got %0d expected 1", cnt_dram); end

    apply_reset();
    model_req(27'h10, 1'b0, hit);
    run_req(27'h10, 1'b0, lat, d);
    tick();
    inval = 1'b1; tick(); inval = 1'b0; m_vld = 1'b0;
    model_req(27'h11, 1'b0, hit);
    run_req(27'h11, 1'b0, lat, d);
    tick();
    n_checks++; if (lat != 3 || cnt_dram !== 32'd2) begin n_fail++; $display("FAIL lb_inval: got lat %0d cnt_dram %0d expected 3 2", lat, cnt_dram); end
    model_req(27'h12, 1'b1, hit);
    run_req(27'h12, 1'b1, lat, d);
    tick();
    n_checks++; if (lat != 3 || cnt_dram !== 32'd3 || d !== word_of(27'h12)) begin n_fail++; $display("FAIL lb_inval_same_cycle: got lat %0d cnt_dram %0d data %h expected 3 3 %h", lat, cnt_dram, d, word_of(27'h12)); end
  endtask
`endif

  task automatic test_random();
    logic hit;
    logic inv;
    logic [26:0] a;
    int lat;
    logic [31:0] d;
    for (int n = 0; n < 40; n++) begin
      rdy_delay = $urandom_range(0, 3);
      rv_delay  = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) a = 27'($urandom);
      else a = 27'h0040000 | 27'($urandom_range(0, 3) << 2) | 27'($urandom_range(0, 3));
      inv = 1'b0;
`ifdef DRAM_READ_LINEBUF_EN
      if ($urandom_range(0, 5) == 0) begin inval = 1'b1; tick(); inval = 1'b0; m_vld = 1'b0; end
      inv = ($urandom_range(0, 5) == 0);
`endif
      model_req(a, inv, hit);
      run_req(a, inv, lat, d);
      n_checks++; if (d !== word_of(a)) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %h expected %h (addr %h)", n, d, word_of(a), a); end
      n_checks++; if (lat != exp_lat(hit)) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, exp_lat(hit)); end
      tick();
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rand_busy[%0d]: got %b expected 0", n, bus.busy); end
      n_checks++; if (cnt_req !== 32'(exp_req) || cnt_dram !== 32'(exp_dram)) begin
        n_fail++; $display("FAIL rand_cnt[%0d]: got %0d %0d expected %0d %0d", n, cnt_req, cnt_dram, exp_req, exp_dram);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    bus.oe = 1'b0;
    bus.addr = '0;
    bus.dram_cmd_rdy = 1'b0;
    bus.dram_rd_valid = 1'b0;
    bus.dram_rd_data = '0;
`ifdef DRAM_READ_LINEBUF_EN
    inval = 1'b0;
    m_vld = 1'b0;
    m_line = '0;
`endif
    test_reset();
    test_min_latency();
    test_rdy_stall();
    test_overrun();
    test_reset_in_wait();
    test_back_to_back();
`ifdef DRAM_READ_LINEBUF_EN
    test_linebuf();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
